// File: rtl/div.sv
// -----------------------------------------------------------------------------
// div -- iterative 32-bit integer divider for the EX stage (MIPS DIV / DIVU)
//
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// clock, followed by a sign fix-up. Shares the start/ready/flush handshake
// of the multiply unit, so the EX controller drives both blocks identically.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
//   opdata1_i     dividend; sampled at accept
//   opdata2_i     divisor; sampled at accept
//   start_i       request, held high by the requester until ready_o
//   flush         pipeline flush; aborts any operation in progress
//   result_o      {remainder, quotient}; valid only while ready_o = 1
//   ready_o       one-cycle done pulse
//
// Timing (default build): accept at the edge ending cycle T, BUSY during
// T+1..T+32, END in T+33, ready_o high during T+34 only. A zero divisor
// skips the iterations and reports {dividend, all-ones} during T+2.
//
// Optional build macro DIV_EARLY_OUT_EN: the dividend magnitude is pre-shifted
// by its leading-zero count at accept and only max(1, 32 - clz) iterations
// run, so ready_o arrives in T+iters+2. Results match the default build.
// -----------------------------------------------------------------------------
module div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 flush,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    // Counter wide enough to hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        DIVZERO,
        BUSY,
        END
    } state_t;

    state_t             state;
    state_t             state_nxt;

    // Working registers: dvd shifts the dividend out at the top and collects
    // quotient bits at the bottom; rem holds the partial remainder.
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dsr;
    logic [WIDTH-1:0]   rem;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      iters;
    logic               neg_q;
    logic               neg_r;

    logic               accept;
    logic               div_by_zero;
    logic               op1_neg;
    logic               op2_neg;
    logic [WIDTH-1:0]   mag1;
    logic [WIDTH-1:0]   mag2;
    logic [WIDTH-1:0]   dvd_init;
    logic [CW-1:0]      iters_init;

    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   dvd_nxt;
    logic               last_iter;

    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [2*WIDTH-1:0] result_d;
    logic               ready_d;

    // A request is taken only in IDLE, never in the same cycle as a flush,
    // and never in the cycle that is still showing the previous ready pulse:
    // the requester drops start_i on seeing ready_o, so start_i being high in
    // that cycle belongs to the operation that just finished.
    assign accept      = (state == IDLE) && start_i && !flush && !ready_o;
    assign div_by_zero = (opdata2_i == '0);

    // Operand conditioning at accept: magnitudes for DIV, raw values for DIVU.
    // The most negative value maps onto itself, which is the correct unsigned
    // magnitude and makes the 0x80000000 / -1 overflow wrap naturally.
    always_comb begin
        op1_neg = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg = signed_div_i & opdata2_i[WIDTH-1];
        mag1    = op1_neg ? ('0 - opdata1_i) : opdata1_i;
        mag2    = op2_neg ? ('0 - opdata2_i) : opdata2_i;
    end

`ifdef DIV_EARLY_OUT_EN
    // Leading-zero count of the dividend magnitude; an all-zero word gives WIDTH.
    function automatic logic [CW-1:0] count_lz(input logic [WIDTH-1:0] v);
        logic [CW-1:0] n;
        logic          hit;
        n   = '0;
        hit = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) begin
                    hit = 1'b1;
                end else begin
                    n = n + CW'(1);
                end
            end
        end
        return n;
    endfunction

    logic [CW-1:0] clz;

    // Skipping the leading zeros of the dividend skips iterations that could
    // only produce zero quotient bits. The vacated low bits of dvd are zero,
    // so after the shortened run the quotient sits right-aligned in dvd with
    // zeros above it, exactly as a full run would leave it.
    always_comb begin
        clz        = count_lz(mag1);
        dvd_init   = mag1 << clz;
        iters_init = (clz == CW'(WIDTH)) ? CW'(1) : (CW'(WIDTH) - clz);
    end
`else
    // Full-length run: every operation takes WIDTH iterations.
    always_comb begin
        dvd_init   = mag1;
        iters_init = CW'(WIDTH);
    end

    assign iters = CW'(WIDTH);
`endif

    // One restoring step: shift {rem, dvd} left, trial-subtract the divisor
    // and keep the difference only if it did not go negative. trial carries an
    // extra bit because twice a remainder can exceed WIDTH bits when the
    // divisor is large.
    always_comb begin
        trial     = {rem, dvd[WIDTH-1]};
        diff      = trial - {1'b0, dsr};
        q_bit     = ~diff[WIDTH];
        rem_nxt   = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_nxt   = {dvd[WIDTH-2:0], q_bit};
        last_iter = (cnt == (iters - CW'(1)));
    end

    // State register; reset and flush both return the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = div_by_zero ? DIVZERO : BUSY;
                end
            end
            DIVZERO: state_nxt = IDLE;
            BUSY: begin
                if (last_iter) begin
                    state_nxt = END;
                end
            end
            END:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the value to be registered into result_o/ready_o at the
    // end of the current cycle. Only DIVZERO and END produce a non-zero value,
    // so result_o reads zero in every cycle except the ready pulse.
    always_comb begin
        q_fix    = neg_q ? ('0 - dvd) : dvd;
        r_fix    = neg_r ? ('0 - rem) : rem;
        result_d = '0;
        ready_d  = 1'b0;
        case (state)
            DIVZERO: begin
                result_d = {dvd, {WIDTH{1'b1}}};
                ready_d  = 1'b1;
            end
            END: begin
                result_d = {r_fix, q_fix};
                ready_d  = 1'b1;
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers. On a zero divisor the raw dividend is
    // kept instead of its magnitude, because it is reported back unchanged.
    // The quotient sign is s1 ^ s2 and the remainder follows the dividend;
    // both are already masked to zero for unsigned operations.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            dvd      <= '0;
            dsr      <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            iters    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    rem <= '0;
                    cnt <= '0;
                    if (accept) begin
                        dvd   <= div_by_zero ? opdata1_i : dvd_init;
                        dsr   <= mag2;
                        neg_q <= op1_neg ^ op2_neg;
                        neg_r <= op1_neg;
`ifdef DIV_EARLY_OUT_EN
                        iters <= iters_init;
`endif
                    end
                end
                BUSY: begin
                    rem <= rem_nxt;
                    dvd <= dvd_nxt;
                    cnt <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

`ifndef DIV_EARLY_OUT_EN
    // In the full-length build the accept-time iteration count is a constant
    // that nothing needs to latch.
    logic unused_iters_init;
    assign unused_iters_init = ^iters_init;
`endif

endmodule

// File: tb/tb_div.sv
// -----------------------------------------------------------------------------
// tb_div -- self-checking bench for the iterative divider.
// Vectors come from a table of {operands, expected result}; expected latency
// and result are pushed to a scoreboard when a request is driven and popped
// when ready_o pulses. Hand-written sequences cover flush/reset aborts,
// flush colliding with start, and back-to-back requests.
// -----------------------------------------------------------------------------
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        flush;
    logic [63:0] result_o;
    logic        ready_o;

    // 10 ns clock.
    always #5 clk = ~clk;

    div #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .flush        (flush),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [63:0] exp;
        int          lat;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[$];
    int   applied     = 0;
    int   miscompares = 0;

    // Reference model built on the simulator's own integer division. Signed
    // arithmetic is done in 64 bits, so the most-negative / -1 case yields
    // +2^31 whose low word is 0x80000000.
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, dv, q, r;
        logic [31:0] uq, ur;
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (sgn) begin
            sa = longint'($signed(a));
            dv = longint'($signed(b));
            q  = sa / dv;
            r  = sa % dv;
            return {r[31:0], q[31:0]};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Expected number of cycles from the accept cycle T to the ready cycle.
    function automatic int exp_lat(input vec_t v);
`ifdef DIV_EARLY_OUT_EN
        logic [31:0] mag;
        int          clz;
        int          it;
        bit          hit;
`endif
        if (v.b == 32'd0) return 2;
`ifdef DIV_EARLY_OUT_EN
        mag = (v.sgn && v.a[31]) ? (32'd0 - v.a) : v.a;
        clz = 0;
        hit = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!hit) begin
                if (mag[i]) hit = 1'b1;
                else clz++;
            end
        end
        it = 32 - clz;
        if (it < 1) it = 1;
        return it + 2;
`else
        return 34;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    // Drive a request at the next falling edge (cycle T) and record what it
    // should produce.
    task automatic applyStimulus(input vec_t v);
        sb_t e;
        @(negedge clk);
        signed_div_i = v.sgn;
        opdata1_i    = v.a;
        opdata2_i    = v.b;
        start_i      = 1'b1;
        e.exp        = v.exp;
        e.lat        = exp_lat(v);
        sb.push_back(e);
    endtask

    // Wait for ready_o (bounded), compare latency and result against the
    // scoreboard, then confirm the following cycle is quiet. Operands are
    // scrambled one cycle after accept to show they are not re-sampled.
    // With chain set, start_i stays high and the next request is presented
    // in the ready cycle so it is accepted in the very next IDLE cycle.
    task automatic checkOutput(input string name, input bit chain, input vec_t nxt);
        int  n;
        bit  seen;
        sb_t e;
        sb_t ne;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (ready_o) seen = 1'b1;
        end
        if (!seen) begin
            applied++;
            miscompares++;
            $display("[TB] FAIL %s timeout: no ready_o within 200 cycles", name);
            start_i = 1'b0;
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            applied++;
            miscompares++;
            $display("[TB] FAIL %s: ready_o with empty scoreboard", name);
            start_i = 1'b0;
            return;
        end
        e = sb.pop_front();
        check({name, " latency"}, 64'(n), 64'(e.lat));
        check({name, " result"}, result_o, e.exp);
        if (chain) begin
            signed_div_i = nxt.sgn;
            opdata1_i    = nxt.a;
            opdata2_i    = nxt.b;
            ne.exp       = nxt.exp;
            ne.lat       = exp_lat(nxt);
            sb.push_back(ne);
        end else begin
            start_i = 1'b0;
        end
        @(negedge clk);
        check({name, " ready after pulse"}, 64'(ready_o), 64'd0);
        check({name, " result after pulse"}, result_o, 64'd0);
    endtask

    // Start an operation, kill it with flush or rst during T+10, then restart
    // in T+12; the restart must complete with its full latency from T+12.
    task automatic abortSeq(input bit use_rst);
        vec_t  v;
        bit    rdy;
        string nm;
        nm = use_rst ? "abort rst" : "abort flush";
`ifdef DIV_EARLY_OUT_EN
        v.a = 32'hFFFFFFF0;
`else
        v.a = 32'd100;
`endif
        v.sgn = 1'b0;
        v.b   = 32'd7;
        v.exp = model(v.sgn, v.a, v.b);
        @(negedge clk);
        signed_div_i = v.sgn;
        opdata1_i    = v.a;
        opdata2_i    = v.b;
        start_i      = 1'b1;
        rdy          = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            if (ready_o) rdy = 1'b1;
            if (n == 10) begin
                if (use_rst) rst = 1'b1;
                else flush = 1'b1;
                start_i = 1'b0;
            end
            if (n == 11) begin
                rst   = 1'b0;
                flush = 1'b0;
            end
        end
        check({nm, " no ready"}, 64'(rdy), 64'd0);
        check({nm, " result zero"}, result_o, 64'd0);
        applyStimulus(v);
        checkOutput({nm, " restart"}, 1'b0, v);
    endtask

    // Bound the whole run in case the DUT wedges somewhere unexpected.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, table vectors, corner-case sequences, summary.
    initial begin
        vec_t v;
        vec_t v2;
        bit   rdy;

        tbl.push_back('{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E});
        tbl.push_back('{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD});
        tbl.push_back('{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC});
        tbl.push_back('{1'b0, 32'h12345678,   32'd0,          64'h12345678_FFFFFFFF});
        tbl.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000});
        tbl.push_back('{1'b1, 32'h00000000,   32'd5,          64'h00000000_00000000});
        tbl.push_back('{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD});
        tbl.push_back('{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF});
        tbl.push_back('{1'b1, 32'hFEDCBA98,   32'd0,          64'hFEDCBA98_FFFFFFFF});
        tbl.push_back('{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E});
        tbl.push_back('{1'b0, 32'd5,          32'd9,          64'h00000005_00000000});
        tbl.push_back('{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001});
        for (int i = 0; i < 8; i++) begin
            v.sgn = 1'(i % 2);
            v.a   = $urandom;
            v.b   = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 6) v.a = 32'($urandom_range(0, 255));
            v.exp = model(v.sgn, v.a, v.b);
            tbl.push_back(v);
        end

        rst          = 1'b1;
        flush        = 1'b0;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (3) @(negedge clk);
        check("reset result", result_o, 64'd0);
        check("reset ready", 64'(ready_o), 64'd0);
        rst = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d", i), 1'b0, tbl[i]);
        end

        $display("[TB] abort sequences");
        abortSeq(1'b0);
        abortSeq(1'b1);

        $display("[TB] flush colliding with start");
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        flush        = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        flush   = 1'b0;
        rdy     = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready_o) rdy = 1'b1;
        end
        check("flush+start not accepted", 64'(rdy), 64'd0);

        $display("[TB] back-to-back");
        v  = '{1'b0, 32'd100, 32'd7, 64'h00000002_0000000E};
        v2 = '{1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD};
        applyStimulus(v);
        checkOutput("b2b first", 1'b1, v2);
        checkOutput("b2b second", 1'b0, v2);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/div.md
Name: div

Overview:
- Iterative 32-bit integer divider for the EX stage; it serves MIPS DIV/DIVU.
- Uses the same start/ready/flush handshake as the multiply unit, so the EX controller drives both blocks the same way.
- Produces {remainder, quotient} for the HI/LO write.
- Radix-2 restoring algorithm on operand magnitudes, with a sign fix-up at the end.

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH. Only 32 is verified.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
- opdata1_i  input  32  dividend; sampled at accept
- opdata2_i  input  32  divisor; sampled at accept
- start_i  input  1  request; the requester holds it high until ready_o
- flush  input  1  pipeline flush; aborts any operation
- result_o  output  64  [63:32] remainder (HI), [31:0] quotient (LO)
- ready_o  output  1  one-cycle done pulse; result_o is valid only while ready_o=1

Behaviour:
- Priority: rst > flush > normal operation.
- Reset: clk and rst only; reset is synchronous, active-high.
  - rst or flush at a clock edge forces state=IDLE, result_o=0, ready_o=0, counter=0, and clears the internal operand/sign registers.
  - This applies from any state, including mid-operation; no partial result is ever emitted.
- States: IDLE, DIVZERO, BUSY, END.
- IDLE:
  - result_o=0, ready_o=0.
  - Accept occurs at the edge ending cycle T when start_i=1 and flush=0.
  - On accept, latch |opdata1_i| and |opdata2_i|. Magnitudes apply only when signed_div_i=1; otherwise raw values are latched.
  - Also latch the quotient sign (s1 XOR s2) and the remainder sign (s1), where s1/s2 are the operand sign bits.
  - Go to DIVZERO if opdata2_i==0, else to BUSY.
  - Counter=0 and the partial remainder is cleared.
- BUSY:
  - One restoring iteration per cycle: shift {rem, dividend} left by 1, trial-subtract the divisor, set the quotient bit.
  - Counter increments each cycle.
  - After the 32nd iteration (cycle T+32), go to END.
- END:
  - At the closing edge of its cycle, register result_o with the sign fix-up.
  - Quotient is negated when the quotient sign=1 and signed.
  - Remainder is negated when the remainder sign=1 and signed.
  - Set ready_o=1 and go to IDLE.
- Latency:
  - Accept at T → BUSY T+1..T+32 → END T+33 → ready_o=1 during T+34 only.
  - In T+35, ready_o=0 and result_o=0.
- DIVZERO:
  - result_o = {dividend as given, 32'hFFFFFFFF}, ready_o=1 during T+2; then IDLE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, via natural 32-bit wrap. No trap.
- Back-to-back: if start_i is still high in the IDLE cycle after ready_o, a new operation is accepted with freshly sampled operands. The requester drops start_i on ready_o.
- Operand changes while busy are ignored.
- flush and start_i high in the same IDLE cycle: not accepted.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - At accept, compute clz of the dividend magnitude.
  - Pre-shift the dividend left by clz and run iters = max(1, 32 − clz) BUSY cycles.
  - ready_o is high in cycle T+iters+2.
  - Dividend 0 runs 1 iteration.
  - Results are identical to the non-early-out build.
- Undefined: iters is always 32; no clz logic.

Test Plan:
- Unsigned 100 / 7, accept at T → ready_o=1 only in T+34; result_o=0x00000002_0000000E.
- Signed 0xFFFFFFF9 / 2 → 0xFFFFFFFF_FFFFFFFD (q=−3, r=−1).
- Unsigned 0xFFFFFFF9 / 2 → 0x00000001_7FFFFFFC.
- Divide by zero 0x12345678 / 0 → ready_o in T+2; result_o=0x12345678_FFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF → 0x00000000_80000000.
- Abort:
  - Start unsigned 100 / 7, assert flush in T+10 → no ready_o, result_o stays 0, state IDLE in T+11.
  - Repeat with rst in T+10 → same response.
  - Re-start in T+12 → ready_o in T+46 with 0x00000002_0000000E.
- With DIV_EARLY_OUT_EN: 100 / 7 (clz=25, iters=7) → ready_o in T+9; same result value.
